// File: rtl/puf_authenticator.sv
// puf_authenticator
//   Runs a fixed-length challenge/response sequence against an external PUF.
//   In enroll mode the responses are stored as the reference fingerprint.
//   In verify mode each response is compared against the stored fingerprint,
//   and the Hamming distances are summed. The result passes when the total
//   does not exceed HD_THRESH.
//
// Ports
//   clk_i            single clock, all state updates on the rising edge
//   reset_i          asynchronous active-high reset
//   start_i          run request (only looked at while idle)
//   mode_i           0 = enroll, 1 = verify (captured with start_i)
//   seed_i           first challenge value (captured with start_i)
//   puf_challenge_o  challenge presented to the PUF
//   puf_reset_o      parity-toggle line to the PUF reset input
//   puf_done_i       PUF idle flag, low while the PUF is measuring
//   puf_response_i   PUF response bits
//   busy_o           high whenever the controller is not idle
//   done_o           one-cycle pulse at the end of every run
//   pass_o           verify verdict, held until the next accepted start
//   hd_o             accumulated Hamming distance, held likewise
//   error_o          run aborted, held likewise
//   enrolled_o       fingerprint store holds a valid enrollment
module puf_authenticator #(
  parameter int NUM_CHAL    = 4,
  parameter int HD_THRESH   = 3,
  parameter int ARM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic [7:0] seed_i,
  output logic [7:0] puf_challenge_o,
  output logic       puf_reset_o,
  input  logic       puf_done_i,
  input  logic [7:0] puf_response_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] hd_o,
  output logic       error_o,
  output logic       enrolled_o
);

  localparam int IW = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [7:0]    HD_THR8  = 8'(HD_THRESH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHAL - 1);
  localparam logic [TW-1:0] ARM_LAST = TW'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_MEASURE, S_SETTLE, S_SAMPLE, S_FINISH
  } state_t;

  state_t          state_q;
  logic            mode_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   arm_cnt_q;
  logic [7:0]      puf_challenge_q;
  logic            puf_reset_q;
  logic            busy_q, done_q, pass_q, error_q, enrolled_q;
  logic [7:0]      hd_q;
  logic [7:0]      store_q [NUM_CHAL];

  logic [7:0]      chal_d;
  logic [7:0]      hd_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  // Choose the reset-line level so that the parity of {reset, challenge}
  // always inverts on a new issue. The PUF then sees an edge even when
  // the new challenge happens to equal the old one.
  function automatic logic toggle_reset(input logic r_old, input logic [7:0] c_old,
                                        input logic [7:0] c_new);
    return ~(r_old ^ (^c_old)) ^ (^c_new);
  endfunction

  // While sampling, the current challenge is SEED+i, so the next one is +1.
  assign chal_d = puf_challenge_q + 8'd1;
  assign hd_d   = mode_q ? (hd_q + {4'b0000, popcount8(puf_response_i ^ store_q[idx_q])})
                         : hd_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      mode_q          <= 1'b0;
      idx_q           <= '0;
      arm_cnt_q       <= '0;
      puf_challenge_q <= 8'h00;
      puf_reset_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      hd_q            <= 8'h00;
      error_q         <= 1'b0;
      enrolled_q      <= 1'b0;
      for (int k = 0; k < NUM_CHAL; k++) store_q[k] <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            pass_q  <= 1'b0;
            hd_q    <= 8'h00;
            error_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (mode_i && !enrolled_q) begin
              // Nothing to verify against: abort without touching the PUF.
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              puf_challenge_q <= seed_i;
              puf_reset_q     <= toggle_reset(puf_reset_q, puf_challenge_q, seed_i);
              state_q         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          arm_cnt_q <= '0;
          state_q   <= S_ARM;
        end
        S_ARM: begin
          if (!puf_done_i) begin
            state_q <= S_MEASURE;
          end else if (arm_cnt_q == ARM_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            if (!mode_q) enrolled_q <= 1'b0;
            state_q <= S_FINISH;
          end else begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
          end
        end
        S_MEASURE: begin
          if (puf_done_i) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (!mode_q) store_q[idx_q] <= puf_response_i;
          hd_q <= hd_d;
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            pass_q  <= mode_q && (hd_d <= HD_THR8);
            if (!mode_q) enrolled_q <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            idx_q           <= idx_q + 1'b1;
            puf_challenge_q <= chal_d;
            puf_reset_q     <= toggle_reset(puf_reset_q, puf_challenge_q, chal_d);
            state_q         <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign puf_challenge_o = puf_challenge_q;
  assign puf_reset_o     = puf_reset_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign hd_o            = hd_q;
  assign error_o         = error_q;
  assign enrolled_o      = enrolled_q;

endmodule

// File: tb/tb_puf_authenticator.sv
// tb_puf_authenticator
//   Drives enroll/verify runs against puf_authenticator with a reactive PUF
//   model, and checks each run against a run-level reference model. The
//   reference model holds the expected challenge list, HD sum, verdict and
//   enrollment state.
module tb_puf_authenticator;
  localparam int NUM_CHAL    = 4;
  localparam int HD_THRESH   = 3;
  localparam int ARM_TIMEOUT = 16;

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, mode_i, puf_done_i;
  logic [7:0] seed_i, puf_response_i, puf_challenge_o, hd_o;
  logic       puf_reset_o, busy_o, done_o, pass_o, error_o, enrolled_o;

  puf_authenticator #(
    .NUM_CHAL(NUM_CHAL), .HD_THRESH(HD_THRESH), .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .seed_i(seed_i), .puf_challenge_o(puf_challenge_o), .puf_reset_o(puf_reset_o),
    .puf_done_i(puf_done_i), .puf_response_i(puf_response_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .hd_o(hd_o), .error_o(error_o),
    .enrolled_o(enrolled_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // PUF model / issue monitor
  logic [7:0] resp_q[$];
  logic [7:0] issued_q[$];
  logic       par_q[$];
  int         hang_idx = -1;
  int         last_issue_cyc = 0;
  bit         puf_busy = 1'b0;

  initial begin
    logic [8:0] prev;
    logic [7:0] rsp;
    int d1, d2;
    prev = 9'h000;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        prev = 9'h000;
      end else if ({puf_reset_o, puf_challenge_o} != prev) begin
        prev = {puf_reset_o, puf_challenge_o};
        issued_q.push_back(puf_challenge_o);
        par_q.push_back(^prev);
        last_issue_cyc = cyc;
        rsp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
        if (issued_q.size() - 1 != hang_idx) begin
          puf_busy = 1'b1;
          d1 = $urandom_range(0, 3);
          d2 = $urandom_range(2, 4);
          repeat (d1) @(negedge clk_i);
          puf_done_i = 1'b0;
          puf_response_i = 8'($urandom);
          repeat (d2) @(negedge clk_i);
          puf_response_i = rsp;
          puf_done_i = 1'b1;
          puf_busy = 1'b0;
        end
      end
    end
  end

  // Reference model state
  logic [7:0] m_store [NUM_CHAL];
  bit         m_enrolled = 1'b0;
  logic       m_par = 1'b0;
  logic [7:0] m_chal = 8'h00;
  int         txn = 0;

  // data: enroll -> PUF responses; verify -> bit-flip mask vs the enrolled values
  task automatic run_txn(input bit mode, input logic [7:0] seed,
                         input logic [7:0] data [NUM_CHAL], input int hang);
    logic [7:0] exp_chal[$];
    bit         exp_err, exp_pass;
    logic [7:0] exp_hd;
    logic       exp_p;
    int         n_iss, n_ok, cnt, done_cyc;
    issued_q.delete(); par_q.delete(); resp_q.delete();
    hang_idx = hang;
    exp_hd = 8'h00;
    exp_err = 1'b0;
    if (mode && !m_enrolled) begin
      exp_err = 1'b1;
      n_iss = 0;
    end else begin
      n_iss = (hang >= 0) ? hang + 1 : NUM_CHAL;
      n_ok  = (hang >= 0) ? hang : NUM_CHAL;
      for (int k = 0; k < NUM_CHAL; k++)
        resp_q.push_back(mode ? (m_store[k] ^ data[k]) : data[k]);
      for (int k = 0; k < n_iss; k++) exp_chal.push_back(seed + 8'(k));
      if (hang >= 0) exp_err = 1'b1;
      if (mode) begin
        for (int k = 0; k < n_ok; k++) exp_hd += 8'($countones(data[k]));
      end else if (!exp_err) begin
        for (int k = 0; k < NUM_CHAL; k++) m_store[k] = data[k];
        m_enrolled = 1'b1;
      end else begin
        m_enrolled = 1'b0;
      end
    end
    exp_pass = mode && !exp_err && (exp_hd <= 8'(HD_THRESH));

    mode_i = mode; seed_i = seed; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    cnt = 0;
    while (!done_o && cnt < 400) begin
      // Stray requests while busy must be ignored.
      if (busy_o && $urandom_range(0, 5) == 0) begin
        start_i = 1'b1; mode_i = $urandom_range(0, 1); seed_i = 8'($urandom);
      end
      @(negedge clk_i);
      start_i = 1'b0;
      cnt++;
    end
    if (!done_o) begin
      check("done_wait", 0, 1);
      return;
    end
    done_cyc = cyc;
    check("error", error_o, exp_err);
    check("hd", hd_o, exp_hd);
    check("pass", pass_o, exp_pass);
    check("enrolled", enrolled_o, m_enrolled);
    check("busy_finish", busy_o, 1);
    check("issue_count", issued_q.size(), n_iss);
    for (int k = 0; k < n_iss; k++) begin
      exp_p = ~m_par;
      if (k < issued_q.size()) begin
        check($sformatf("chal%0d", k), issued_q[k], exp_chal[k]);
        check($sformatf("parity%0d", k), par_q[k], exp_p);
      end
      m_par = exp_p;
      m_chal = exp_chal[k];
    end
    check("chal_hold", puf_challenge_o, m_chal);
    if (hang >= 0 && issued_q.size() == n_iss)
      check("arm_timeout_cycles", done_cyc - last_issue_cyc, ARM_TIMEOUT + 1);
    @(negedge clk_i);
    check("done_pulse_width", done_o, 0);
    check("busy_idle", busy_o, 0);
    check("hd_held", hd_o, exp_hd);
    check("pass_held", pass_o, exp_pass);
    check("error_held", error_o, exp_err);
    $display("txn %0d: mode=%0d seed=%02h hang=%0d issues=%0d hd=%0d pass=%0d err=%0d enrolled=%0d",
             txn, mode, seed, hang, issued_q.size(), hd_o, pass_o, error_o, enrolled_o);
    txn++;
  endtask

  logic [7:0] d [NUM_CHAL];

  initial begin
    int wcnt;
    reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; seed_i = 8'h00;
    puf_done_i = 1'b1; puf_response_i = 8'h00;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_hd", hd_o, 0);
    check("rst_error", error_o, 0);
    check("rst_enrolled", enrolled_o, 0);
    check("rst_chal", puf_challenge_o, 0);
    check("rst_pufreset", puf_reset_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1'b1, 8'h55, d, -1);                  // verify while not enrolled
    d = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    run_txn(1'b0, 8'h10, d, -1);                  // directed enroll
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1'b1, 8'h10, d, -1);                  // identical -> HD 0
    d = '{8'h01, 8'h00, 8'h12, 8'h00};
    run_txn(1'b1, 8'h10, d, -1);                  // 3 flips -> pass
    d = '{8'h01, 8'h80, 8'h00, 8'h41};
    run_txn(1'b1, 8'h10, d, -1);                  // 4 flips -> fail
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1'b1, 8'h10, d, 2);                   // arm timeout in verify
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_txn(1'b0, 8'hFE, d, -1);                  // challenge wrap-around

    for (int r = 0; r < 24; r++) begin
      bit   md;
      int   hg;
      md = ($urandom_range(0, 9) >= 4);
      hg = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NUM_CHAL - 1)) : -1;
      for (int k = 0; k < NUM_CHAL; k++) begin
        if (md) begin
          d[k] = 8'h00;
          for (int b = 0; b < int'($urandom_range(0, 2)); b++)
            d[k][$urandom_range(0, 7)] = 1'b1;
        end else begin
          d[k] = 8'($urandom);
        end
      end
      run_txn(md, 8'($urandom), d, hg);
    end

    // Make sure an enrollment exists, then reset in the middle of a run.
    d = '{8'h5A, 8'hC3, 8'h99, 8'h66};
    run_txn(1'b0, 8'h40, d, -1);
    issued_q.delete(); par_q.delete(); resp_q.delete(); hang_idx = -1;
    mode_i = 1'b0; seed_i = 8'h80; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_pass", pass_o, 0);
    check("midrst_hd", hd_o, 0);
    check("midrst_error", error_o, 0);
    check("midrst_enrolled", enrolled_o, 0);
    check("midrst_chal", puf_challenge_o, 0);
    check("midrst_pufreset", puf_reset_o, 0);
    m_enrolled = 1'b0; m_par = 1'b0; m_chal = 8'h00;
    repeat (10) @(negedge clk_i);
    reset_i = 1'b0;
    wcnt = 0;
    while (puf_busy && wcnt < 50) begin
      @(negedge clk_i);
      wcnt++;
    end
    check("puf_model_idle", puf_busy, 0);
    @(negedge clk_i);
    check("post_rst_busy", busy_o, 0);
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1'b1, 8'h21, d, -1);                  // store was wiped by reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
